// File: rtl/pool_frame_arbiter_if.sv
// ----------------------------------------------------------------------------
// pool_frame_arbiter_if
//   Bundle of the frame arbiter's channel, pool-unit and result signals.
//   NUM_CH : number of requesting channels (2..8)
//
//   req/grant        : per-channel frame request (level) and one-hot grant
//   ch_valid/ch_data : per-channel pixel strobe and packed 8-bit pixels
//   pool_in_*        : pixel stream towards the shared max-pool unit
//   pool_out_*       : pooled results coming back from the max-pool unit
//   out_*            : pooled results tagged with the source channel id
//   frame_done/busy  : end-of-frame pulse and arbiter activity flag
//
//   slave  : the arbiter side
//   master : the producers / pool unit / consumer side
// ----------------------------------------------------------------------------
interface pool_frame_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   ch_valid;
  logic [8*NUM_CH-1:0] ch_data;
  logic                pool_in_valid;
  logic [7:0]          pool_in_data;
  logic                pool_out_valid;
  logic [7:0]          pool_out_data;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [2:0]          out_ch;
  logic                frame_done;
  logic                busy;

  modport slave (
    input  req, ch_valid, ch_data, pool_out_valid, pool_out_data,
    output grant, pool_in_valid, pool_in_data, out_valid, out_data, out_ch,
           frame_done, busy
  );

  modport master (
    output req, ch_valid, ch_data, pool_out_valid, pool_out_data,
    input  grant, pool_in_valid, pool_in_data, out_valid, out_data, out_ch,
           frame_done, busy
  );
endinterface

// File: rtl/pool_frame_arbiter.sv
// ----------------------------------------------------------------------------
// pool_frame_arbiter
//   Shares one 2x2/stride-2 max-pool unit between NUM_CH feature-map
//   producers. A whole IMG_W x IMG_H frame is granted to one channel, its
//   pixels are streamed into the pool unit, and all pooled results of that
//   frame are collected (tagged with the channel id) before re-arbitrating.
//
//   Ports:
//     clk     : rising-edge clock
//     rst     : synchronous, active-high reset (pool unit is reset alongside)
//     pfa_if  : pool_frame_arbiter_if.slave (req/grant, channel pixels,
//               pool unit in/out, tagged results, frame_done, busy)
//
//   Configuration macro:
//     POOL_ARB_FIXED_PRIO_EN : when defined, IDLE always grants the
//                              lowest-index requester and rr_ptr stays 0;
//                              when undefined, round-robin arbitration.
// ----------------------------------------------------------------------------
module pool_frame_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                clk,
  input  logic                rst,
  pool_frame_arbiter_if.slave pfa_if
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W / 2) * (IMG_H / 2);
  localparam int PIX_W = $clog2(NPIX);
  localparam int OUT_W = $clog2(NOUT + 1);
  localparam int PTR_W = $clog2(NUM_CH);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(NOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e              state_q;
  logic [NUM_CH-1:0]   grant_q;
  logic [PTR_W-1:0]    cur_ch_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [OUT_W-1:0]    out_cnt_q;
  logic                pool_in_valid_q;
  logic [7:0]          pool_in_data_q;
  logic                out_valid_q;
  logic [7:0]          out_data_q;
  logic [2:0]          out_ch_q;
  logic                frame_done_q;
  logic                busy_q;

  logic [PIX_W-1:0]    pix_cnt_d;
  logic [OUT_W-1:0]    out_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_d;
  logic [NUM_CH-1:0]   grant_d;
  logic                pick_vld_s;
  logic [PTR_W-1:0]    pick_ch_s;
  logic [PTR_W-1:0]    scan_idx_s;
  logic                cur_valid_s;
  logic [7:0]          cur_data_s;
  logic [2:0]          cur_ch_ext_s;

  assign pix_cnt_d    = pix_cnt_q + PIX_W'(1);
  assign out_cnt_d    = out_cnt_q + OUT_W'(1);
  assign grant_d      = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_ch_s;
  assign cur_valid_s  = pfa_if.ch_valid[cur_ch_q];
  assign cur_data_s   = pfa_if.ch_data[{cur_ch_q, 3'b000} +: 8];
  assign cur_ch_ext_s = 3'(cur_ch_q);

`ifdef POOL_ARB_FIXED_PRIO_EN
  // Pointer never moves, so the scan below always starts at channel 0.
  assign rr_ptr_d = '0;
`else
  // Next frame starts the scan just after the channel that was served.
  assign rr_ptr_d = (cur_ch_q == PTR_W'(NUM_CH - 1)) ? '0 : cur_ch_q + PTR_W'(1);
`endif

  // Requester picker: scanning in reverse lets the first hit in order
  // rr_ptr, rr_ptr+1, ... be the last assignment, avoiding an early exit.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_ch_s  = '0;
    scan_idx_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan_idx_s = PTR_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (pfa_if.req[scan_idx_s]) begin
        pick_vld_s = 1'b1;
        pick_ch_s  = scan_idx_s;
      end else begin
        pick_vld_s = pick_vld_s;
        pick_ch_s  = pick_ch_s;
      end
    end
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      cur_ch_q        <= '0;
      rr_ptr_q        <= '0;
      pix_cnt_q       <= '0;
      out_cnt_q       <= '0;
      pool_in_valid_q <= 1'b0;
      pool_in_data_q  <= 8'h00;
      out_valid_q     <= 1'b0;
      out_data_q      <= 8'h00;
      out_ch_q        <= 3'd0;
      frame_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      pool_in_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      // Result path is a plain pipeline stage, muted only while idle.
      out_valid_q     <= pfa_if.pool_out_valid && (state_q != S_IDLE);
      out_data_q      <= pfa_if.pool_out_data;
      out_ch_q        <= cur_ch_ext_s;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_s) begin
            grant_q  <= grant_d;
            cur_ch_q <= pick_ch_s;
            busy_q   <= 1'b1;
            state_q  <= S_STREAM;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_STREAM: begin
          pool_in_valid_q <= cur_valid_s;
          pool_in_data_q  <= cur_data_s;
          // Pooled results already appear while the frame is streaming.
          if (pfa_if.pool_out_valid) begin
            out_cnt_q <= out_cnt_d;
          end else begin
            out_cnt_q <= out_cnt_q;
          end
          if (cur_valid_s) begin
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_q <= '0;
              state_q   <= S_DRAIN;
            end else begin
              pix_cnt_q <= pix_cnt_d;
            end
          end else begin
            pix_cnt_q <= pix_cnt_q;
          end
        end
        S_DRAIN: begin
          if (pfa_if.pool_out_valid) begin
            if (out_cnt_q == OUT_LAST) begin
              // Last pooled result: pulse frame_done alongside its out_valid.
              frame_done_q <= 1'b1;
              grant_q      <= '0;
              rr_ptr_q     <= rr_ptr_d;
              out_cnt_q    <= '0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              out_cnt_q    <= out_cnt_d;
            end
          end else begin
            out_cnt_q <= out_cnt_q;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          grant_q   <= '0;
          pix_cnt_q <= '0;
          out_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pfa_if.grant         = grant_q;
  assign pfa_if.pool_in_valid = pool_in_valid_q;
  assign pfa_if.pool_in_data  = pool_in_data_q;
  assign pfa_if.out_valid     = out_valid_q;
  assign pfa_if.out_data      = out_data_q;
  assign pfa_if.out_ch        = out_ch_q;
  assign pfa_if.frame_done    = frame_done_q;
  assign pfa_if.busy          = busy_q;

endmodule

// File: tb/tb_pool_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pool_frame_arbiter
//   Directed bench for pool_frame_arbiter with a behavioural 2x2 max-pool
//   unit attached. Expected pooled values come from a direct block-max over
//   the generated pixel pattern.
// ----------------------------------------------------------------------------
module tb_pool_frame_arbiter;
  localparam int NUM_CH = 4;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = NPIX / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_frame_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  pool_frame_arbiter #(.NUM_CH(NUM_CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk    (clk),
    .rst    (rst),
    .pfa_if (bus)
  );

  int checks = 0;
  int passes = 0;

  function automatic logic signed [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Pixel pattern p at raster index k.
  function automatic logic [7:0] pat(input int p, input int k);
    int v;
    v = (p == 0) ? k : (k * 37 + 11);
    return v[7:0];
  endfunction

  // Expected pooled value j (raster order of 2x2 blocks).
  function automatic logic [7:0] exp_out(input int p, input int j);
    int br, bc, b;
    br = j / (IMG_W / 2);
    bc = j % (IMG_W / 2);
    b  = 2 * br * IMG_W + 2 * bc;
    return smax(smax(pat(p, b), pat(p, b + 1)), smax(pat(p, b + IMG_W), pat(p, b + IMG_W + 1)));
  endfunction

  // Behavioural max-pool unit, registered output, reset together with the DUT.
  logic signed [7:0] lbuf [IMG_W];
  logic signed [7:0] prev_px;
  int pm_row, pm_col;
  always @(posedge clk) begin
    if (rst) begin
      pm_row <= 0;
      pm_col <= 0;
      bus.pool_out_valid <= 1'b0;
      bus.pool_out_data  <= 8'h00;
    end else begin
      bus.pool_out_valid <= 1'b0;
      if (bus.pool_in_valid) begin
        prev_px <= bus.pool_in_data;
        if (pm_row % 2 == 0) lbuf[pm_col] <= bus.pool_in_data;
        else if (pm_col % 2 == 1) begin
          bus.pool_out_valid <= 1'b1;
          bus.pool_out_data  <= smax(smax(lbuf[pm_col-1], lbuf[pm_col]), smax(prev_px, bus.pool_in_data));
        end
        if (pm_col == IMG_W - 1) begin
          pm_col <= 0;
          pm_row <= (pm_row == IMG_H - 1) ? 0 : pm_row + 1;
        end else begin
          pm_col <= pm_col + 1;
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [7:0] cap_data [$];
  logic [2:0] cap_ch   [$];
  int cyc = 0, fd_cnt = 0, fd_aligned = 0, pin_cnt = 0, glitch = 0;
  int min_gap = 1000, last_fd = -1000;
  logic [NUM_CH-1:0] grant_prev = '0, frame_grant = '0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid) begin
      cap_data.push_back(bus.out_data);
      cap_ch.push_back(bus.out_ch);
    end
    if (bus.frame_done) begin
      fd_cnt  <= fd_cnt + 1;
      last_fd <= cyc;
      if (bus.out_valid) fd_aligned <= fd_aligned + 1;
    end
    if (bus.pool_in_valid) pin_cnt <= pin_cnt + 1;
    if (grant_prev == '0 && bus.grant != '0) begin
      frame_grant <= bus.grant;
      if (cyc - last_fd < min_gap) min_gap <= cyc - last_fd;
    end else if (bus.busy && bus.grant != frame_grant) begin
      glitch <= glitch + 1;
    end
    if (!bus.busy && bus.grant != '0) glitch <= glitch + 1;
    grant_prev <= bus.grant;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_pixels(input int ch, input int p, input int gap, input int n, input bit interf);
    for (int k = 0; k < n; k++) begin
      bus.ch_valid[ch] = 1'b1;
      bus.ch_data[8*ch +: 8] = pat(p, k);
      if (interf) begin
        bus.ch_valid[0] = ~bus.ch_valid[0];
        bus.ch_data[7:0] = 8'($urandom);
        if (k == 11) bus.req[ch] = 1'b0;
      end
      @(posedge clk); #1;
      for (int g = 0; g < gap; g++) begin
        bus.ch_valid[ch] = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.ch_valid = '0;
  endtask

  task automatic run_frame(input int ch, input int p, input int gap, input bit drop_req, input bit interf);
    int t, s0, fd0, fa0, pin0, gl0;
    logic [NUM_CH-1:0] oh;
    s0 = cap_data.size(); fd0 = fd_cnt; fa0 = fd_aligned; pin0 = pin_cnt; gl0 = glitch;
    oh = '0;
    oh[ch] = 1'b1;
    t = 0;
    while (bus.grant == '0 && t < 20) begin @(posedge clk); #1; t++; end
    check($sformatf("grant_ch%0d", ch), 32'(bus.grant), 32'(oh));
    drive_pixels(ch, p, gap, NPIX, interf);
    if (drop_req) bus.req = '0;
    t = 0;
    while (bus.frame_done !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    check("frame_done_seen", 32'(bus.frame_done), 32'd1);
    @(negedge clk); #1;
    check("out_count", 32'(cap_data.size() - s0), 32'(NOUT));
    check("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    check("frame_done_with_last", 32'(fd_aligned - fa0), 32'd1);
    check("pool_in_count", 32'(pin_cnt - pin0), 32'(NPIX));
    check("grant_held", 32'(glitch - gl0), 32'd0);
    for (int j = 0; j < NOUT && s0 + j < cap_data.size(); j++) begin
      check($sformatf("out_data[%0d]", j), 32'(cap_data[s0+j]), 32'(exp_out(p, j)));
      check($sformatf("out_ch[%0d]", j), 32'(cap_ch[s0+j]), 32'(ch));
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.req = '0;
    bus.ch_valid = '0;
    bus.ch_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_pool_in_valid", 32'(bus.pool_in_valid), 32'd0);

    // Single frame on ch1, ramp pattern.
    bus.req = 4'b0010;
    run_frame(1, 0, 0, 1'b1, 1'b0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`ifdef POOL_ARB_FIXED_PRIO_EN
    // Fixed priority: ch1 wins twice over ch3.
    bus.req = 4'b1010;
    run_frame(1, 1, 0, 1'b0, 1'b0);
    run_frame(1, 0, 0, 1'b1, 1'b0);
`else
    // Round robin with all channels requesting.
    bus.req = 4'b1111;
    run_frame(0, 1, 0, 1'b0, 1'b0);
    run_frame(1, 0, 0, 1'b0, 1'b0);
    run_frame(2, 1, 0, 1'b0, 1'b0);
    run_frame(3, 0, 0, 1'b0, 1'b0);
    run_frame(0, 1, 0, 1'b1, 1'b0);
`endif
    check("min_idle_gap_ge1", 32'(min_gap >= 1), 32'd1);

    // Gapped input, 1-in-3 duty on ch0.
    bus.req = 4'b0001;
    run_frame(0, 0, 2, 1'b1, 1'b0);

    // Interference from ch0 while ch2 streams; req[2] drops mid-frame.
    bus.req = 4'b0100;
    run_frame(2, 1, 0, 1'b1, 1'b1);

    // Reset in the middle of a ch1 frame, then a clean ch3 frame.
    bus.req = 4'b0010;
    t = 0;
    while (bus.grant == '0 && t < 20) begin @(posedge clk); #1; t++; end
    check("t5_grant", 32'(bus.grant), 32'h2);
    drive_pixels(1, 0, 0, 400, 1'b0);
    bus.req = '0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_pool_in_valid", 32'(bus.pool_in_valid), 32'd0);
    bus.req = 4'b1000;
    run_frame(3, 1, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
